apb_wakeup_cfg_master: RTL and testbench

//  APB initiator that drives the wakeup/PMU register slave from a simple valid/ready command port.

---
 rtl/apb_wakeup_pkg.sv | 21 ++
 rtl/apb_wakeup_cfg_master_if.sv | 41 ++++
 rtl/apb_wakeup_cfg_tmo.sv | 36 +++
 rtl/apb_wakeup_cfg_master.sv | 136 +++++++++++++
 tb/tb_apb_wakeup_cfg_master.sv | 315 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/apb_wakeup_pkg.sv
// Shared definitions for the wakeup/PMU APB register slave and its configuration master.
//   - register byte offsets inside the wakeup block
//   - fixed signature value readable at offset 0
//   - APB master FSM state encoding
package apb_wakeup_pkg;

    localparam logic [3:0] WU_ADDR_SIGNATURE = 4'h0;
    localparam logic [3:0] WU_ADDR_SCRATCH   = 4'h4;
    localparam logic [3:0] WU_ADDR_PMU_EN    = 4'h8;
    localparam logic [3:0] WU_ADDR_PMU_MODE  = 4'hC;

    localparam logic [31:0] WU_SIGNATURE = 32'h00DA41DE;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2,
        RESP   = 2'd3
    } apb_mst_state_e;

endpackage

// File: rtl/apb_wakeup_cfg_master_if.sv
// Bus bundle for apb_wakeup_cfg_master: command/response port toward the SoC control
// FSM plus the APB initiator signals toward the wakeup slave.
//   master modport : the APB initiator (drives cmd_ready/rsp_*/busy and APB requests)
//   slave  modport : the environment (drives commands, rsp_ready and APB completion)
interface apb_wakeup_cfg_master_if #(
    parameter int APB_ADDR_WIDTH = 12
);
    logic                      cmd_valid_i;
    logic                      cmd_ready_o;
    logic                      cmd_write_i;
    logic [APB_ADDR_WIDTH-1:0] cmd_addr_i;
    logic [31:0]               cmd_wdata_i;
    logic                      rsp_valid_o;
    logic                      rsp_ready_i;
    logic [31:0]               rsp_rdata_o;
    logic                      rsp_err_o;
    logic                      rsp_timeout_o;
    logic                      busy_o;
    logic [APB_ADDR_WIDTH-1:0] PADDR;
    logic [31:0]               PWDATA;
    logic                      PWRITE;
    logic                      PSEL;
    logic                      PENABLE;
    logic [31:0]               PRDATA;
    logic                      PREADY;
    logic                      PSLVERR;

    modport master (
        input  cmd_valid_i, cmd_write_i, cmd_addr_i, cmd_wdata_i, rsp_ready_i,
               PRDATA, PREADY, PSLVERR,
        output cmd_ready_o, rsp_valid_o, rsp_rdata_o, rsp_err_o, rsp_timeout_o, busy_o,
               PADDR, PWDATA, PWRITE, PSEL, PENABLE
    );

    modport slave (
        output cmd_valid_i, cmd_write_i, cmd_addr_i, cmd_wdata_i, rsp_ready_i,
               PRDATA, PREADY, PSLVERR,
        input  cmd_ready_o, rsp_valid_o, rsp_rdata_o, rsp_err_o, rsp_timeout_o, busy_o,
               PADDR, PWDATA, PWRITE, PSEL, PENABLE
    );
endinterface

// File: rtl/apb_wakeup_cfg_tmo.sv
// Saturating PREADY wait counter for the APB master.
//   HCLK, HRESET : clock, async active-high reset
//   clr          : restart the count (SETUP phase)
//   inc          : one more ACCESS cycle without PREADY
//   expired      : current ACCESS cycle is the last one allowed (TIMEOUT_CYCLES-1 stalls seen)
module apb_wakeup_cfg_tmo #(
    parameter int TIMEOUT_W      = 16,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic HCLK,
    input  logic HRESET,
    input  logic clr,
    input  logic inc,
    output logic expired
);
    if (TIMEOUT_CYCLES < 0 || longint'(TIMEOUT_CYCLES) >= (64'd1 << TIMEOUT_W)) begin : g_bad_cfg
        $error("apb_wakeup_cfg_tmo: TIMEOUT_CYCLES must fit in TIMEOUT_W bits");
    end

    localparam logic [TIMEOUT_W-1:0] CNT_MAX  = '1;
    // Wraps to all-ones when TIMEOUT_CYCLES is 0; the enable term below masks that case.
    localparam logic [TIMEOUT_W-1:0] CNT_LAST = TIMEOUT_W'(TIMEOUT_CYCLES - 1);

    logic [TIMEOUT_W-1:0] cnt;

    always_ff @(posedge HCLK or posedge HRESET) begin
        if (HRESET)
            cnt <= '0;
        else if (clr)
            cnt <= '0;
        else if (inc && cnt != CNT_MAX)
            cnt <= cnt + 1'b1;
    end

    assign expired = (TIMEOUT_CYCLES != 0) && (cnt == CNT_LAST);
endmodule

// File: rtl/apb_wakeup_cfg_master.sv
// APB initiator for the wakeup/PMU register slave. Each accepted command becomes one
// SETUP/ACCESS transfer; the result (read data, PSLVERR or timeout) is returned on the
// response port and held until consumed. One command outstanding at a time.
//   HCLK, HRESET : clock, async active-high reset
//   bus (master) : cmd_* / rsp_* / busy_o handshake and the APB request/response signals
module apb_wakeup_cfg_master
    import apb_wakeup_pkg::*;
#(
    parameter int APB_ADDR_WIDTH = 12,
    parameter int TIMEOUT_W      = 16,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic                   HCLK,
    input  logic                   HRESET,
    apb_wakeup_cfg_master_if.master bus
);
    apb_mst_state_e            state_q, state_d;
    logic                      psel_q, psel_d, penable_q, penable_d, pwrite_q, pwrite_d;
    logic [APB_ADDR_WIDTH-1:0] paddr_q, paddr_d;
    logic [31:0]               pwdata_q, pwdata_d, rdata_q, rdata_d;
    logic                      rsp_valid_q, rsp_valid_d, err_q, err_d, tmo_q, tmo_d;
    logic                      tmo_clr, tmo_inc, tmo_expired;

    apb_wakeup_cfg_tmo #(
        .TIMEOUT_W      (TIMEOUT_W),
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_tmo (
        .HCLK    (HCLK),
        .HRESET  (HRESET),
        .clr     (tmo_clr),
        .inc     (tmo_inc),
        .expired (tmo_expired)
    );

    // Registered outputs are computed from the next state so PSEL/PENABLE/rsp_valid
    // line up with the state the FSM is entering.
    always_comb begin
        state_d     = state_q;
        psel_d      = psel_q;
        penable_d   = penable_q;
        pwrite_d    = pwrite_q;
        paddr_d     = paddr_q;
        pwdata_d    = pwdata_q;
        rsp_valid_d = rsp_valid_q;
        rdata_d     = rdata_q;
        err_d       = err_q;
        tmo_d       = tmo_q;
        tmo_clr     = 1'b0;
        tmo_inc     = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.cmd_valid_i) begin
                    state_d  = SETUP;
                    psel_d   = 1'b1;
                    pwrite_d = bus.cmd_write_i;
                    paddr_d  = bus.cmd_addr_i;
                    pwdata_d = bus.cmd_write_i ? bus.cmd_wdata_i : 32'h0;
                end
            end
            SETUP: begin
                state_d   = ACCESS;
                penable_d = 1'b1;
                tmo_clr   = 1'b1;
            end
            ACCESS: begin
                // PREADY is tested first so a completion on the last allowed cycle wins.
                if (bus.PREADY) begin
                    state_d     = RESP;
                    psel_d      = 1'b0;
                    penable_d   = 1'b0;
                    rsp_valid_d = 1'b1;
                    rdata_d     = pwrite_q ? 32'h0 : bus.PRDATA;
                    err_d       = bus.PSLVERR;
                    tmo_d       = 1'b0;
                end else begin
                    tmo_inc = 1'b1;
                    if (tmo_expired) begin
                        state_d     = RESP;
                        psel_d      = 1'b0;
                        penable_d   = 1'b0;
                        rsp_valid_d = 1'b1;
                        rdata_d     = 32'h0;
                        err_d       = 1'b1;
                        tmo_d       = 1'b1;
                    end
                end
            end
            RESP: begin
                if (bus.rsp_ready_i) begin
                    state_d     = IDLE;
                    rsp_valid_d = 1'b0;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge HCLK or posedge HRESET) begin
        if (HRESET) begin
            state_q     <= IDLE;
            psel_q      <= 1'b0;
            penable_q   <= 1'b0;
            pwrite_q    <= 1'b0;
            paddr_q     <= '0;
            pwdata_q    <= '0;
            rsp_valid_q <= 1'b0;
            rdata_q     <= '0;
            err_q       <= 1'b0;
            tmo_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            psel_q      <= psel_d;
            penable_q   <= penable_d;
            pwrite_q    <= pwrite_d;
            paddr_q     <= paddr_d;
            pwdata_q    <= pwdata_d;
            rsp_valid_q <= rsp_valid_d;
            rdata_q     <= rdata_d;
            err_q       <= err_d;
            tmo_q       <= tmo_d;
        end
    end

    // Ready is gated by reset so it reads 0 while held and 1 in the very first IDLE cycle after release.
    assign bus.cmd_ready_o   = (state_q == IDLE) && !HRESET;
    assign bus.busy_o        = (state_q != IDLE);
    assign bus.rsp_valid_o   = rsp_valid_q;
    assign bus.rsp_rdata_o   = rdata_q;
    assign bus.rsp_err_o     = err_q;
    assign bus.rsp_timeout_o = tmo_q;
    assign bus.PSEL          = psel_q;
    assign bus.PENABLE       = penable_q;
    assign bus.PWRITE        = pwrite_q;
    assign bus.PADDR         = paddr_q;
    assign bus.PWDATA        = pwdata_q;
endmodule

// File: tb/tb_apb_wakeup_cfg_master.sv
// Self-checking bench for apb_wakeup_cfg_master: a behavioural wakeup slave with
// configurable wait states / error injection drives the main instance, and a second
// instance built with an 8-cycle timeout is driven directly for the abort cases.
module tb_apb_wakeup_cfg_master;
    import apb_wakeup_pkg::*;

    logic HCLK;
    logic HRESET;
    int   n_chk  = 0;
    int   n_pass = 0;

    apb_wakeup_cfg_master_if #(.APB_ADDR_WIDTH(12)) m_if ();
    apb_wakeup_cfg_master_if #(.APB_ADDR_WIDTH(12)) t_if ();

    apb_wakeup_cfg_master #(.APB_ADDR_WIDTH(12), .TIMEOUT_W(16), .TIMEOUT_CYCLES(1024)) dut (
        .HCLK(HCLK), .HRESET(HRESET), .bus(m_if));
    apb_wakeup_cfg_master #(.APB_ADDR_WIDTH(12), .TIMEOUT_W(16), .TIMEOUT_CYCLES(8)) dut_t (
        .HCLK(HCLK), .HRESET(HRESET), .bus(t_if));

    initial begin
        HCLK = 1'b0;
        forever #5 HCLK = ~HCLK;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    // Behavioural slave for the main instance: s_stall low-PREADY ACCESS cycles, then completes.
    int          s_stall = 0;
    logic        s_err   = 1'b0;
    int          s_wait  = 0;
    logic [31:0] s_mem [4] = '{WU_SIGNATURE, 32'h0, 32'h1, 32'h2};

    always @(negedge HCLK) begin
        if (m_if.PSEL && m_if.PENABLE && s_wait >= s_stall) begin
            m_if.PREADY  = 1'b1;
            m_if.PSLVERR = s_err;
            m_if.PRDATA  = m_if.PWRITE ? $urandom() : s_mem[m_if.PADDR[3:2]];
            if (m_if.PWRITE && !s_err && m_if.PADDR[3:2] != 2'd0)
                s_mem[m_if.PADDR[3:2]] = m_if.PWDATA;
        end else begin
            if (m_if.PSEL && m_if.PENABLE) s_wait++;
            else s_wait = 0;
            m_if.PREADY  = 1'b0;
            m_if.PSLVERR = 1'b0;
            m_if.PRDATA  = $urandom();
        end
    end

    // Reference model: register contents expected in the slave.
    logic [31:0] ref_mem [4] = '{WU_SIGNATURE, 32'h0, 32'h1, 32'h2};

    // Drives one command on the main instance and returns what came back.
    task automatic xact(input logic wr, input logic [11:0] a, input logic [31:0] d,
                        input int stall, input logic e,
                        output logic [31:0] rd, output logic er, output logic to,
                        output int lat, output logic stable);
        s_stall = stall;
        s_err   = e;
        m_if.cmd_valid_i = 1'b1;
        m_if.cmd_write_i = wr;
        m_if.cmd_addr_i  = a;
        m_if.cmd_wdata_i = d;
        @(posedge HCLK);
        @(negedge HCLK);
        m_if.cmd_valid_i = 1'b0;
        m_if.cmd_write_i = ~wr;
        m_if.cmd_addr_i  = 12'($urandom());
        m_if.cmd_wdata_i = $urandom();
        lat    = 1;
        stable = 1'b1;
        while (!m_if.rsp_valid_o && lat < 200) begin
            if (!(m_if.PSEL && (m_if.PENABLE == (lat > 1)) && m_if.PADDR == a &&
                  m_if.PWRITE == wr && m_if.PWDATA == (wr ? d : 32'h0)))
                stable = 1'b0;
            @(negedge HCLK);
            lat++;
        end
        if (m_if.PSEL || m_if.PENABLE) stable = 1'b0;
        rd = m_if.rsp_rdata_o;
        er = m_if.rsp_err_o;
        to = m_if.rsp_timeout_o;
        m_if.rsp_ready_i = 1'b1;
        @(negedge HCLK);
        m_if.rsp_ready_i = 1'b0;
    endtask

    task automatic test_reset();
        repeat (3) @(negedge HCLK);
        n_chk++;
        if ({m_if.PSEL, m_if.PENABLE, m_if.rsp_valid_o, m_if.cmd_ready_o, m_if.busy_o,
             m_if.rsp_err_o, m_if.rsp_timeout_o, m_if.rsp_rdata_o, m_if.PADDR, m_if.PWDATA} !== '0)
            $display("FAIL reset_outputs: got psel=%b pen=%b rv=%b rdy=%b busy=%b, want all 0",
                     m_if.PSEL, m_if.PENABLE, m_if.rsp_valid_o, m_if.cmd_ready_o, m_if.busy_o);
        else n_pass++;
        HRESET = 1'b0;
        #1;
        n_chk++;
        if ({m_if.cmd_ready_o, t_if.cmd_ready_o, m_if.busy_o} !== 3'b110)
            $display("FAIL reset_release_ready: got rdy=%b rdy_t=%b busy=%b, want 1 1 0",
                     m_if.cmd_ready_o, t_if.cmd_ready_o, m_if.busy_o);
        else n_pass++;
        @(negedge HCLK);
    endtask

    task automatic test_read_signature();
        logic [31:0] rd; logic er, to, st; int lat;
        xact(1'b0, 12'h000, 32'h0, 0, 1'b0, rd, er, to, lat, st);
        n_chk++;
        if (rd !== WU_SIGNATURE) $display("FAIL sig_rdata: got %h want %h", rd, WU_SIGNATURE);
        else n_pass++;
        n_chk++;
        if ({er, to} !== 2'b00) $display("FAIL sig_err: got err=%b tmo=%b want 0 0", er, to);
        else n_pass++;
        n_chk++;
        if (lat !== 3 || st !== 1'b1) $display("FAIL sig_latency: got lat=%0d stable=%b want 3 1", lat, st);
        else n_pass++;
    endtask

    task automatic test_write_stall();
        logic [31:0] rd; logic er, to, st; int lat;
        xact(1'b1, 12'h004, 32'hCAFE0001, 40, 1'b0, rd, er, to, lat, st);
        ref_mem[1] = 32'hCAFE0001;
        n_chk++;
        if (st !== 1'b1) $display("FAIL stall_apb_stable: got stable=%b want 1", st);
        else n_pass++;
        n_chk++;
        if (lat !== 43) $display("FAIL stall_latency: got %0d want 43", lat);
        else n_pass++;
        n_chk++;
        if ({rd, er, to} !== {32'h0, 2'b00}) $display("FAIL stall_rsp: got rdata=%h err=%b tmo=%b want 0 0 0", rd, er, to);
        else n_pass++;
        xact(1'b0, 12'h004, 32'h0, 0, 1'b0, rd, er, to, lat, st);
        n_chk++;
        if (rd !== 32'hCAFE0001) $display("FAIL stall_readback: got %h want cafe0001", rd);
        else n_pass++;
    endtask

    task automatic test_slverr();
        logic [31:0] rd; logic er, to, st; int lat;
        xact(1'b0, 12'h008, 32'h0, 2, 1'b1, rd, er, to, lat, st);
        n_chk++;
        if ({er, to} !== 2'b10) $display("FAIL slverr_flags: got err=%b tmo=%b want 1 0", er, to);
        else n_pass++;
        n_chk++;
        if (rd !== ref_mem[2]) $display("FAIL slverr_rdata: got %h want %h", rd, ref_mem[2]);
        else n_pass++;
    endtask

    task automatic test_random();
        logic [31:0] rd, d; logic er, to, st, wr, e; int lat, stall; logic [1:0] idx;
        for (int i = 0; i < 24; i++) begin
            wr    = 1'($urandom_range(0, 1));
            idx   = 2'($urandom_range(0, 3));
            d     = $urandom();
            stall = $urandom_range(0, 5);
            e     = ($urandom_range(0, 7) == 0);
            xact(wr, {8'h0, idx, 2'b00}, d, stall, e, rd, er, to, lat, st);
            n_chk++;
            if ({rd, er, to} !== {(wr ? 32'h0 : ref_mem[idx]), e, 1'b0})
                $display("FAIL rand_rsp[%0d]: got rdata=%h err=%b tmo=%b want %h %b 0",
                         i, rd, er, to, wr ? 32'h0 : ref_mem[idx], e);
            else n_pass++;
            n_chk++;
            if (lat !== 3 + stall || st !== 1'b1)
                $display("FAIL rand_timing[%0d]: got lat=%0d stable=%b want %0d 1", i, lat, st, 3 + stall);
            else n_pass++;
            if (wr && !e && idx != 2'd0) ref_mem[idx] = d;
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] r0, nd; logic ok; int c;
        s_stall = 0; s_err = 1'b0;
        nd = $urandom();
        m_if.cmd_valid_i = 1'b1; m_if.cmd_write_i = 1'b0; m_if.cmd_addr_i = 12'h00C; m_if.cmd_wdata_i = 32'h0;
        @(posedge HCLK);
        @(negedge HCLK);
        m_if.cmd_write_i = 1'b1; m_if.cmd_wdata_i = nd;
        c = 0;
        while (!m_if.rsp_valid_o && c < 50) begin @(negedge HCLK); c++; end
        r0 = m_if.rsp_rdata_o;
        n_chk++;
        if (r0 !== ref_mem[3]) $display("FAIL b2b_rdata: got %h want %h", r0, ref_mem[3]);
        else n_pass++;
        ok = 1'b1;
        for (int k = 0; k < 10; k++) begin
            if (!(m_if.rsp_valid_o && m_if.rsp_rdata_o == r0 && !m_if.cmd_ready_o && !m_if.PSEL && !m_if.PENABLE))
                ok = 1'b0;
            @(negedge HCLK);
        end
        n_chk++;
        if (ok !== 1'b1) $display("FAIL b2b_hold: got hold_ok=%b want 1", ok);
        else n_pass++;
        m_if.rsp_ready_i = 1'b1;
        @(negedge HCLK);
        m_if.rsp_ready_i = 1'b0;
        n_chk++;
        if ({m_if.rsp_valid_o, m_if.cmd_ready_o, m_if.PSEL} !== 3'b010)
            $display("FAIL b2b_after_hs: got rv=%b rdy=%b psel=%b want 0 1 0",
                     m_if.rsp_valid_o, m_if.cmd_ready_o, m_if.PSEL);
        else n_pass++;
        @(negedge HCLK);
        m_if.cmd_valid_i = 1'b0;
        n_chk++;
        if ({m_if.PSEL, m_if.PENABLE, m_if.PWRITE, m_if.PADDR, m_if.PWDATA} !== {3'b101, 12'h00C, nd})
            $display("FAIL b2b_next_setup: got psel=%b pen=%b pw=%b addr=%h wd=%h want 1 0 1 00c %h",
                     m_if.PSEL, m_if.PENABLE, m_if.PWRITE, m_if.PADDR, m_if.PWDATA, nd);
        else n_pass++;
        c = 0;
        while (!m_if.rsp_valid_o && c < 50) begin @(negedge HCLK); c++; end
        n_chk++;
        if ({m_if.rsp_valid_o, m_if.rsp_err_o, m_if.rsp_rdata_o} !== {2'b10, 32'h0})
            $display("FAIL b2b_write_rsp: got rv=%b err=%b rdata=%h want 1 0 0",
                     m_if.rsp_valid_o, m_if.rsp_err_o, m_if.rsp_rdata_o);
        else n_pass++;
        ref_mem[3] = nd;
        m_if.rsp_ready_i = 1'b1;
        @(negedge HCLK);
        m_if.rsp_ready_i = 1'b0;
    endtask

    task automatic test_timeout();
        int acc, c; logic [31:0] v;
        for (int pass = 0; pass < 2; pass++) begin
            v = $urandom();
            t_if.PREADY = 1'b0; t_if.PSLVERR = 1'b0; t_if.PRDATA = 32'h0;
            t_if.cmd_valid_i = 1'b1; t_if.cmd_write_i = 1'b0; t_if.cmd_addr_i = 12'h008;
            @(posedge HCLK);
            @(negedge HCLK);
            t_if.cmd_valid_i = 1'b0;
            acc = 0; c = 0;
            while (!t_if.rsp_valid_o && c < 100) begin
                if (t_if.PSEL && t_if.PENABLE) begin
                    acc++;
                    if (pass == 1 && acc == 8) begin t_if.PREADY = 1'b1; t_if.PRDATA = v; end
                end
                @(negedge HCLK);
                c++;
            end
            t_if.PREADY = 1'b0;
            n_chk++;
            if (acc !== 8 || t_if.PSEL !== 1'b0 || t_if.PENABLE !== 1'b0)
                $display("FAIL tmo_access_cycles[%0d]: got acc=%0d psel=%b pen=%b want 8 0 0",
                         pass, acc, t_if.PSEL, t_if.PENABLE);
            else n_pass++;
            n_chk++;
            if (pass == 0 && {t_if.rsp_valid_o, t_if.rsp_timeout_o, t_if.rsp_err_o, t_if.rsp_rdata_o} !== {3'b111, 32'h0})
                $display("FAIL tmo_abort: got rv=%b tmo=%b err=%b rdata=%h want 1 1 1 0",
                         t_if.rsp_valid_o, t_if.rsp_timeout_o, t_if.rsp_err_o, t_if.rsp_rdata_o);
            else if (pass == 1 && {t_if.rsp_valid_o, t_if.rsp_timeout_o, t_if.rsp_err_o, t_if.rsp_rdata_o} !== {3'b100, v})
                $display("FAIL tmo_late_ready: got rv=%b tmo=%b err=%b rdata=%h want 1 0 0 %h",
                         t_if.rsp_valid_o, t_if.rsp_timeout_o, t_if.rsp_err_o, t_if.rsp_rdata_o, v);
            else n_pass++;
            t_if.rsp_ready_i = 1'b1;
            @(negedge HCLK);
            t_if.rsp_ready_i = 1'b0;
        end
    endtask

    task automatic test_reset_mid();
        logic [31:0] rd; logic er, to, st, bad; int lat, c;
        s_stall = 20; s_err = 1'b0;
        m_if.cmd_valid_i = 1'b1; m_if.cmd_write_i = 1'b1; m_if.cmd_addr_i = 12'h004; m_if.cmd_wdata_i = $urandom();
        @(posedge HCLK);
        @(negedge HCLK);
        m_if.cmd_valid_i = 1'b0;
        c = 0;
        while (!m_if.PENABLE && c < 10) begin @(negedge HCLK); c++; end
        repeat (2) @(negedge HCLK);
        HRESET = 1'b1;
        #1;
        n_chk++;
        if ({m_if.PSEL, m_if.PENABLE, m_if.rsp_valid_o, m_if.busy_o} !== 4'b0000)
            $display("FAIL midrst_drop: got psel=%b pen=%b rv=%b busy=%b want 0 0 0 0",
                     m_if.PSEL, m_if.PENABLE, m_if.rsp_valid_o, m_if.busy_o);
        else n_pass++;
        repeat (2) @(negedge HCLK);
        HRESET = 1'b0;
        bad = 1'b0;
        for (int k = 0; k < 30; k++) begin
            @(negedge HCLK);
            if (m_if.rsp_valid_o || m_if.PSEL || m_if.busy_o || !m_if.cmd_ready_o) bad = 1'b1;
        end
        n_chk++;
        if (bad !== 1'b0) $display("FAIL midrst_quiet: got activity=%b want 0", bad);
        else n_pass++;
        xact(1'b0, 12'h004, 32'h0, 0, 1'b0, rd, er, to, lat, st);
        n_chk++;
        if (rd !== ref_mem[1]) $display("FAIL midrst_readback: got %h want %h", rd, ref_mem[1]);
        else n_pass++;
    endtask

    initial begin
        HRESET = 1'b1;
        m_if.cmd_valid_i = 1'b0; m_if.cmd_write_i = 1'b0; m_if.cmd_addr_i = '0;
        m_if.cmd_wdata_i = '0;   m_if.rsp_ready_i = 1'b0;
        t_if.cmd_valid_i = 1'b0; t_if.cmd_write_i = 1'b0; t_if.cmd_addr_i = '0;
        t_if.cmd_wdata_i = '0;   t_if.rsp_ready_i = 1'b0;
        t_if.PRDATA = '0; t_if.PREADY = 1'b0; t_if.PSLVERR = 1'b0;
        test_reset();
        test_read_signature();
        test_write_stall();
        test_slverr();
        test_random();
        test_back_to_back();
        test_timeout();
        test_reset_mid();
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
